// File: rtl/lcd_cmd_arbiter.sv
// Round-robin arbiter and sequencer for two command requesters in front of the
// LCD controller's single cmd/busy/done port, with a watchdog against a hung controller.
module lcd_cmd_arbiter #(
  parameter int TIMEOUT = 4096,
  parameter int TO_W    = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_req0_valid,
  input  logic [3:0] i_req0_cmd,
  output logic       o_req0_ready,
  input  logic       i_req1_valid,
  input  logic [3:0] i_req1_cmd,
  output logic       o_req1_ready,
  output logic [3:0] o_cmd,
  output logic       o_cmd_valid,
  input  logic       i_busy,
  input  logic       i_done,
  output logic       o_grant_id,
  output logic       o_cmd_done,
  output logic       o_err_illegal,
  output logic       o_err_timeout,
  output logic       o_idle
);

  // state     | meaning
  // BOOT      | waiting for the controller's post-reset image load (busy low)
  // IDLE      | accepting one request while the controller is not busy
  // ISSUE     | one-cycle cmd_valid strobe
  // GUARD     | one cycle ignoring busy while the controller registers it
  // WAIT_BUSY | codes 1..11: waiting for busy low
  // WAIT_DONE | code 0 (write-out): waiting for done
  localparam logic [2:0] S_BOOT      = 3'd0;
  localparam logic [2:0] S_IDLE      = 3'd1;
  localparam logic [2:0] S_ISSUE     = 3'd2;
  localparam logic [2:0] S_GUARD     = 3'd3;
  localparam logic [2:0] S_WAIT_BUSY = 3'd4;
  localparam logic [2:0] S_WAIT_DONE = 3'd5;

  localparam logic            WD_EN   = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] WD_ONE  = TO_W'(1);

  logic [2:0]      r_state;
  logic [3:0]      r_cmd_q;
  logic            r_cmd_valid;
  logic            r_grant_id;
  logic            r_rr;
  logic            r_cmd_done;
  logic            r_err_illegal;
  logic            r_err_timeout;
  logic [TO_W-1:0] r_wd;

  logic [2:0] w_next;
  logic       w_any;
  logic       w_win;
  logic       w_accept;
  logic [3:0] w_win_cmd;
  logic       w_legal;
  logic       w_wait;
  logic       w_wd_state;
  logic       w_exit;
  logic       w_wd_fire;

  // When rr's favoured requester is idle the other one wins, so w_win is
  // only meaningful together with w_any.
  assign w_any     = i_req0_valid | i_req1_valid;
  assign w_win     = r_rr ? i_req1_valid : ~i_req0_valid;
  assign w_accept  = (r_state == S_IDLE) & ~i_busy & w_any;
  assign w_win_cmd = w_win ? i_req1_cmd : i_req0_cmd;
  assign w_legal   = (w_win_cmd < 4'd12);

  assign w_wait     = (r_state == S_WAIT_BUSY) | (r_state == S_WAIT_DONE);
  assign w_wd_state = w_wait | (r_state == S_BOOT);

  always_comb begin
    w_exit = 1'b0;
    case (r_state)
      S_BOOT, S_WAIT_BUSY: w_exit = ~i_busy;
      S_WAIT_DONE:         w_exit = i_done;
      default:             w_exit = 1'b0;
    endcase
  end

  // A normal exit in the same cycle as the terminal count takes priority.
  assign w_wd_fire = WD_EN & w_wd_state & ~w_exit & (r_wd == WD_LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_BOOT:      if (w_exit || w_wd_fire) w_next = S_IDLE;
      S_IDLE:      if (w_accept && w_legal) w_next = S_ISSUE;
      S_ISSUE:     w_next = S_GUARD;
      S_GUARD:     w_next = (r_cmd_q == 4'd0) ? S_WAIT_DONE : S_WAIT_BUSY;
      S_WAIT_BUSY: if (w_exit || w_wd_fire) w_next = S_IDLE;
      S_WAIT_DONE: if (w_exit || w_wd_fire) w_next = S_IDLE;
      default:     w_next = S_BOOT;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= S_BOOT;
      r_cmd_valid   <= 1'b0;
      r_cmd_done    <= 1'b0;
      r_err_illegal <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_cmd_valid   <= (w_next == S_ISSUE);
      r_cmd_done    <= w_wait & w_exit;
      r_err_illegal <= w_accept & ~w_legal;
      r_err_timeout <= w_wd_fire;
    end
  end

  // Only legal codes reach cmd_q, so cmd never shows a rejected code.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cmd_q    <= 4'd0;
      r_grant_id <= 1'b0;
      r_rr       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_grant_id <= w_win;
        if (w_legal) r_cmd_q <= w_win_cmd;
      end
      if ((w_accept & ~w_legal) | (w_wait & (w_exit | w_wd_fire))) r_rr <= ~r_rr;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wd <= '0;
    end else if (w_next != r_state) begin
      r_wd <= '0;
    end else if (w_wd_state) begin
      r_wd <= r_wd + WD_ONE;
    end
  end

  assign o_req0_ready  = w_accept & ~w_win;
  assign o_req1_ready  = w_accept & w_win;
  assign o_cmd         = r_cmd_q;
  assign o_cmd_valid   = r_cmd_valid;
  assign o_grant_id    = r_grant_id;
  assign o_cmd_done    = r_cmd_done;
  assign o_err_illegal = r_err_illegal;
  assign o_err_timeout = r_err_timeout;
  assign o_idle        = (r_state == S_IDLE);

endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
// Directed bench for lcd_cmd_arbiter: a default-watchdog instance for the main
// sequences and a TIMEOUT=16 instance for the watchdog abort.
module tb_lcd_cmd_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       a_req0_valid = 1'b0, a_req1_valid = 1'b0;
  logic [3:0] a_req0_cmd = 4'd0, a_req1_cmd = 4'd0;
  logic       a_req0_ready, a_req1_ready;
  logic [3:0] a_cmd;
  logic       a_cmd_valid, a_busy, a_done = 1'b0;
  logic       a_grant_id, a_cmd_done, a_err_illegal, a_err_timeout, a_idle;
  logic       a_busy_drv = 1'b1;
  logic       bm_en = 1'b0;
  int         bm_cnt = 0;

  logic       b_req0_valid = 1'b0, b_req1_valid = 1'b0;
  logic [3:0] b_req0_cmd = 4'd0, b_req1_cmd = 4'd0;
  logic       b_req0_ready, b_req1_ready;
  logic [3:0] b_cmd;
  logic       b_cmd_valid, b_busy = 1'b0, b_done = 1'b0;
  logic       b_grant_id, b_cmd_done, b_err_illegal, b_err_timeout, b_idle;

  lcd_cmd_arbiter dut_a (
    .i_clk(clk), .i_reset(reset),
    .i_req0_valid(a_req0_valid), .i_req0_cmd(a_req0_cmd), .o_req0_ready(a_req0_ready),
    .i_req1_valid(a_req1_valid), .i_req1_cmd(a_req1_cmd), .o_req1_ready(a_req1_ready),
    .o_cmd(a_cmd), .o_cmd_valid(a_cmd_valid), .i_busy(a_busy), .i_done(a_done),
    .o_grant_id(a_grant_id), .o_cmd_done(a_cmd_done), .o_err_illegal(a_err_illegal),
    .o_err_timeout(a_err_timeout), .o_idle(a_idle)
  );

  lcd_cmd_arbiter #(.TIMEOUT(16), .TO_W(16)) dut_b (
    .i_clk(clk), .i_reset(reset),
    .i_req0_valid(b_req0_valid), .i_req0_cmd(b_req0_cmd), .o_req0_ready(b_req0_ready),
    .i_req1_valid(b_req1_valid), .i_req1_cmd(b_req1_cmd), .o_req1_ready(b_req1_ready),
    .o_cmd(b_cmd), .o_cmd_valid(b_cmd_valid), .i_busy(b_busy), .i_done(b_done),
    .o_grant_id(b_grant_id), .o_cmd_done(b_cmd_done), .o_err_illegal(b_err_illegal),
    .o_err_timeout(b_err_timeout), .o_idle(b_idle)
  );

  // Controller model: busy high for 3 cycles after each issue strobe.
  always @(posedge clk) begin
    if (a_cmd_valid) bm_cnt <= 3;
    else if (bm_cnt != 0) bm_cnt <= bm_cnt - 1;
  end
  assign a_busy = bm_en ? (bm_cnt != 0) : a_busy_drv;

  int n_total = 0;
  int n_bad = 0;
  int errs;
  int n_iss, n_done, both;
  logic [3:0] iss_cmd [4];
  logic       iss_gnt [4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle_a(input int budget);
    int n;
    n = 0;
    while (!a_idle && n < budget) begin
      tick();
      #1;
      n++;
    end
    chk("wait_idle_a", 32'(a_idle), 1);
  endtask

  task automatic do_reset();
    a_req0_valid = 1'b0;
    a_req1_valid = 1'b0;
    a_busy_drv   = 1'b0;
    a_done       = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    wait_idle_a(10);
  endtask

  initial begin
    // reset values and boot hold-off
    a_req0_valid = 1'b1;
    a_req0_cmd   = 4'd4;
    #1 reset = 1'b1;
    #1;
    chk("rst_cmd", 32'(a_cmd), 0);
    chk("rst_cmd_valid", 32'(a_cmd_valid), 0);
    chk("rst_ready0", 32'(a_req0_ready), 0);
    chk("rst_idle", 32'(a_idle), 0);
    chk("rst_grant", 32'(a_grant_id), 0);
    chk("rst_flags", 32'({a_cmd_done, a_err_illegal, a_err_timeout}), 0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    errs = 0;
    for (int k = 0; k < 70; k++) begin
      tick();
      #1;
      if (a_req0_ready || a_cmd_valid || a_idle) errs++;
    end
    chk("boot_quiet", 32'(errs), 0);
    a_busy_drv = 1'b0;
    tick(); #1;
    chk("boot_ready0", 32'(a_req0_ready), 1);
    chk("boot_idle", 32'(a_idle), 1);
    tick(); a_req0_valid = 1'b0; #1;
    chk("boot_cmd_valid", 32'(a_cmd_valid), 1);
    chk("boot_cmd", 32'(a_cmd), 4);
    chk("boot_ready0_off", 32'(a_req0_ready), 0);
    tick(); #1;
    chk("boot_strobe_1cyc", 32'(a_cmd_valid), 0);
    chk("boot_cmd_held", 32'(a_cmd), 4);
    tick(); #1;
    chk("boot_no_early_done", 32'(a_cmd_done), 0);
    tick(); #1;
    chk("boot_cmd_done", 32'(a_cmd_done), 1);
    chk("boot_back_idle", 32'(a_idle), 1);

    // round-robin with both requesters continuously valid
    do_reset();
    bm_en = 1'b1;
    a_req0_cmd = 4'd1; a_req1_cmd = 4'd2;
    a_req0_valid = 1'b1; a_req1_valid = 1'b1;
    n_iss = 0; n_done = 0; both = 0;
    for (int i = 0; i < 4; i++) begin iss_cmd[i] = 4'hf; iss_gnt[i] = 1'b0; end
    for (int c = 0; c < 60 && n_done < 4; c++) begin
      #1;
      if (a_req0_ready && a_req1_ready) both++;
      if (a_cmd_valid && n_iss < 4) begin
        iss_cmd[n_iss] = a_cmd;
        iss_gnt[n_iss] = a_grant_id;
        n_iss++;
      end
      if (a_cmd_done) n_done++;
      tick();
    end
    a_req0_valid = 1'b0; a_req1_valid = 1'b0;
    chk("rr_n_issued", 32'(n_iss), 4);
    chk("rr_n_done", 32'(n_done), 4);
    chk("rr_both_ready", 32'(both), 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr_cmd%0d", i), 32'(iss_cmd[i]), (i % 2 == 0) ? 1 : 2);
      chk($sformatf("rr_gnt%0d", i), 32'(iss_gnt[i]), (i % 2 == 0) ? 0 : 1);
    end
    wait_idle_a(20);
    bm_en = 1'b0;

    // write-out completes only on done; a stray done in GUARD is ignored
    a_req1_cmd = 4'd0; a_req1_valid = 1'b1; #1;
    chk("wo_ready1", 32'(a_req1_ready), 1);
    tick(); a_req1_valid = 1'b0; #1;
    chk("wo_cmd_valid", 32'(a_cmd_valid), 1);
    chk("wo_cmd", 32'(a_cmd), 0);
    chk("wo_grant", 32'(a_grant_id), 1);
    tick(); a_done = 1'b1; #1;
    errs = 0;
    for (int k = 0; k < 64; k++) begin
      if (a_cmd_done || a_idle || a_req0_ready || a_req1_ready) errs++;
      tick(); a_done = 1'b0; a_req0_cmd = 4'd3; a_req0_valid = 1'b1; #1;
    end
    chk("wo_wait_quiet", 32'(errs), 0);
    a_req0_valid = 1'b0; a_done = 1'b1; #1;
    chk("wo_done_cycle_idle", 32'(a_idle), 0);
    tick(); a_done = 1'b0; #1;
    chk("wo_cmd_done", 32'(a_cmd_done), 1);
    chk("wo_idle", 32'(a_idle), 1);
    chk("wo_grant_kept", 32'(a_grant_id), 1);
    tick(); #1;
    chk("wo_done_pulse_end", 32'(a_cmd_done), 0);

    // illegal code is consumed without issue and passes the turn
    do_reset();
    a_req0_cmd = 4'd13; a_req0_valid = 1'b1;
    a_req1_cmd = 4'd7;  a_req1_valid = 1'b1; #1;
    chk("ill_ready0", 32'(a_req0_ready), 1);
    chk("ill_ready1", 32'(a_req1_ready), 0);
    tick(); a_req0_valid = 1'b0; #1;
    chk("ill_err", 32'(a_err_illegal), 1);
    chk("ill_no_issue", 32'(a_cmd_valid), 0);
    chk("ill_idle", 32'(a_idle), 1);
    chk("ill_next_ready1", 32'(a_req1_ready), 1);
    tick(); a_req1_valid = 1'b0; #1;
    chk("ill_err_end", 32'(a_err_illegal), 0);
    chk("ill_issue1", 32'(a_cmd_valid), 1);
    chk("ill_cmd1", 32'(a_cmd), 7);
    chk("ill_grant1", 32'(a_grant_id), 1);
    wait_idle_a(10);

    // reset during WAIT_BUSY: rr left at 1 beforehand, must come back 0
    a_req0_cmd = 4'd2; a_req0_valid = 1'b1;
    tick(); a_req0_valid = 1'b0;
    wait_idle_a(10);
    a_req1_cmd = 4'd5; a_req1_valid = 1'b1; #1;
    chk("mid_ready1", 32'(a_req1_ready), 1);
    tick(); a_req1_valid = 1'b0; a_busy_drv = 1'b1; #1;
    chk("mid_issue", 32'(a_cmd_valid), 1);
    tick(); tick(); tick(); #1;
    chk("mid_waiting", 32'(a_idle), 0);
    chk("mid_grant", 32'(a_grant_id), 1);
    a_req0_cmd = 4'd4; a_req0_valid = 1'b1;
    a_req1_cmd = 4'd6; a_req1_valid = 1'b1;
    reset = 1'b1; #1;
    chk("mid_rst_cmd", 32'(a_cmd), 0);
    chk("mid_rst_grant", 32'(a_grant_id), 0);
    chk("mid_rst_idle", 32'(a_idle), 0);
    chk("mid_rst_ready", 32'({a_req0_ready, a_req1_ready}), 0);
    chk("mid_rst_flags", 32'({a_cmd_valid, a_cmd_done, a_err_illegal, a_err_timeout}), 0);
    tick(); a_busy_drv = 1'b0;
    tick(); reset = 1'b0;
    wait_idle_a(10);
    chk("mid_rr_ready0", 32'(a_req0_ready), 1);
    chk("mid_rr_ready1", 32'(a_req1_ready), 0);
    tick(); a_req0_valid = 1'b0; a_req1_valid = 1'b0; #1;
    chk("mid_rr_cmd", 32'(a_cmd), 4);
    chk("mid_rr_grant", 32'(a_grant_id), 0);
    wait_idle_a(10);

    // watchdog abort with TIMEOUT=16
    for (int n = 0; n < 20 && !b_idle; n++) begin tick(); #1; end
    chk("wd_start_idle", 32'(b_idle), 1);
    b_req0_cmd = 4'd5; b_req0_valid = 1'b1; #1;
    chk("wd_ready0", 32'(b_req0_ready), 1);
    tick(); b_req0_valid = 1'b0; b_busy = 1'b1; #1;
    chk("wd_issue", 32'(b_cmd_valid), 1);
    chk("wd_cmd", 32'(b_cmd), 5);
    errs = 0;
    for (int k = 2; k <= 18; k++) begin
      tick(); #1;
      if (b_err_timeout || b_cmd_done || b_idle) errs++;
    end
    chk("wd_quiet", 32'(errs), 0);
    tick(); #1;
    chk("wd_err", 32'(b_err_timeout), 1);
    chk("wd_idle", 32'(b_idle), 1);
    chk("wd_no_done", 32'(b_cmd_done), 0);
    chk("wd_grant", 32'(b_grant_id), 0);
    tick(); #1;
    chk("wd_err_end", 32'(b_err_timeout), 0);
    chk("wd_busy_no_ready", 32'(b_req0_ready | b_req1_ready), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
